// File: rtl/dht11_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dht11_pkg - shared states, error codes and helpers for dht11_reader   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package dht11_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START_LOW = 3'd1,
      S_WAIT_RESP = 3'd2,
      S_RESP_LOW  = 3'd3,
      S_RESP_HIGH = 3'd4,
      S_BIT_LOW   = 3'd5,
      S_BIT_HIGH  = 3'd6,
      S_CHECK     = 3'd7
   } dht11_state_t;

   localparam logic [1:0] DHT_ERR_NONE    = 2'd0;
   localparam logic [1:0] DHT_ERR_TIMEOUT = 2'd1;
   localparam logic [1:0] DHT_ERR_CSUM    = 2'd2;

   localparam int DHT_FRAME_BITS = 40;

   // Tens digit of %RH; readings of 100 and above clamp to 9.
   function automatic logic [3:0] hum_tens(input logic [7:0] h);
      logic [7:0] q;
      q = h / 8'd10;
      return (q > 8'd9) ? 4'd9 : q[3:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/dht11_us_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dht11_us_tick - divides clk by CLK_HZ/1e6 into a one-cycle us pulse   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module dht11_us_tick #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int DIV = CLK_HZ / 1_000_000;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] div_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else if (div_cnt == CW'(DIV - 1)) begin
         div_cnt <= '0;
         tick    <= 1'b1;
      end else begin
         div_cnt <= div_cnt + CW'(1);
         tick    <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dht11_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dht11_reader - DHT11 single-wire reader; optional DHT11_AUTO_TRIG_EN  |
// | adds a periodic self-trigger. Revision: 1.0                           |
// +----------------------------------------------------------------------+
module dht11_reader
   import dht11_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int START_LOW_US   = 18000,
   parameter int TIMEOUT_US     = 200,
   parameter int BIT1_US        = 40,
   parameter int AUTO_PERIOD_MS = 2000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       dht_in,
   output logic       dht_oe,
   output logic       busy,
   output logic       valid,
   output logic       err,
   output logic [1:0] err_code,
   output logic [7:0] humidity,
   output logic [7:0] temperature,
   output logic [3:0] humidity10
);

   logic tick;

   dht11_us_tick #(.CLK_HZ(CLK_HZ)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Idle line is high, so the synchronizer resets high to avoid a false edge.
   logic sync1, sync2, sync_prev;
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         sync_prev <= 1'b1;
      end else begin
         sync1     <= dht_in;
         sync2     <= sync1;
         sync_prev <= sync2;
      end
   end

   logic rise, fall;
   assign rise = sync2 & ~sync_prev;
   assign fall = ~sync2 & sync_prev;

   logic trigger;
`ifdef DHT11_AUTO_TRIG_EN
   logic [9:0]  us_cnt;
   logic [31:0] ms_cnt;
   logic        auto_trig;
   always_ff @(posedge clk) begin
      if (rst) begin
         us_cnt    <= '0;
         ms_cnt    <= '0;
         auto_trig <= 1'b0;
      end else begin
         auto_trig <= 1'b0;
         if (tick) begin
            if (us_cnt == 10'd999) begin
               us_cnt <= '0;
               if (ms_cnt == 32'(AUTO_PERIOD_MS - 1)) begin
                  ms_cnt    <= '0;
                  auto_trig <= 1'b1;
               end else begin
                  ms_cnt <= ms_cnt + 32'd1;
               end
            end else begin
               us_cnt <= us_cnt + 10'd1;
            end
         end
      end
   end
   assign trigger = (start | auto_trig) & ~valid & ~err;
`else
   logic unused_auto_period;
   assign unused_auto_period = (AUTO_PERIOD_MS != 0);
   assign trigger = start & ~valid & ~err;
`endif

   dht11_state_t state, state_nxt;
   logic [15:0]  phase_cnt;
   logic [5:0]   bit_cnt;
   logic [39:0]  shreg;
   logic [7:0]   csum;
   logic         phase_to, accept, shift_en, frame_ok, timeout_fail, csum_fail;

   assign csum     = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];
   assign phase_to = (phase_cnt >= 16'(TIMEOUT_US));
   assign accept   = (state == S_IDLE) & trigger;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      shift_en     = 1'b0;
      frame_ok     = 1'b0;
      timeout_fail = 1'b0;
      csum_fail    = 1'b0;
      case (state)
         S_IDLE:      if (trigger) state_nxt = S_START_LOW;
         S_START_LOW: if (phase_cnt >= 16'(START_LOW_US)) state_nxt = S_WAIT_RESP;
         S_WAIT_RESP: if (fall) state_nxt = S_RESP_LOW;
                      else if (phase_to) begin timeout_fail = 1'b1; state_nxt = S_IDLE; end
         S_RESP_LOW:  if (rise) state_nxt = S_RESP_HIGH;
                      else if (phase_to) begin timeout_fail = 1'b1; state_nxt = S_IDLE; end
         S_RESP_HIGH: if (fall) state_nxt = S_BIT_LOW;
                      else if (phase_to) begin timeout_fail = 1'b1; state_nxt = S_IDLE; end
         S_BIT_LOW:   if (rise) state_nxt = S_BIT_HIGH;
                      else if (phase_to) begin timeout_fail = 1'b1; state_nxt = S_IDLE; end
         S_BIT_HIGH: begin
            if (fall) begin
               shift_en  = 1'b1;
               state_nxt = (bit_cnt == 6'(DHT_FRAME_BITS - 1)) ? S_CHECK : S_BIT_LOW;
            end else if (phase_to) begin
               timeout_fail = 1'b1;
               state_nxt    = S_IDLE;
            end
         end
         S_CHECK: begin
            if (csum == shreg[7:0]) frame_ok  = 1'b1;
            else                    csum_fail = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_cnt   <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         valid       <= 1'b0;
         err         <= 1'b0;
         err_code    <= DHT_ERR_NONE;
         humidity    <= '0;
         temperature <= '0;
         humidity10  <= '0;
      end else begin
         valid <= frame_ok;
         err   <= timeout_fail | csum_fail;
         if (state_nxt != state)             phase_cnt <= '0;
         else if (tick && phase_cnt != '1)   phase_cnt <= phase_cnt + 16'd1;
         if (accept) begin
            err_code <= DHT_ERR_NONE;
            bit_cnt  <= '0;
         end
         if (shift_en) begin
            shreg   <= {shreg[38:0], (phase_cnt >= 16'(BIT1_US))};
            bit_cnt <= bit_cnt + 6'd1;
         end
         if (timeout_fail) err_code <= DHT_ERR_TIMEOUT;
         if (csum_fail)    err_code <= DHT_ERR_CSUM;
         if (frame_ok) begin
            humidity    <= shreg[39:32];
            temperature <= shreg[23:16];
            humidity10  <= hum_tens(shreg[39:32]);
         end
      end
   end

   assign dht_oe = (state == S_START_LOW);
   assign busy   = (state != S_IDLE);

endmodule
`default_nettype wire
